sample_advance: RTL and testbench
=================================

SAMPLE_ADVANCE -- requirements
Module: sample_advance

Interface
REQ-001 SHALL have parameter MAX_LEN_LOG2, default 10, width of discard length and counter.
REQ-002 SHALL have parameter WIDTH, default 16, sample data width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous restart, same effect as reset.
REQ-006 SHALL have port len  input  MAX_LEN_LOG2  number of leading samples to discard.
REQ-007 SHALL have ports i_tdata/i_tlast/i_tvalid  input  WIDTH/1/1, and i_tready  output  1: AXI-Stream sample input.
REQ-008 SHALL have ports o_tdata/o_tlast/o_tvalid  output  WIDTH/1/1, and o_tready  input  1: AXI-Stream sample output.
REQ-009 SHALL have port discarding  output  1  high while in state DISCARD.

Function
REQ-010 SHALL be the receive-side inverse of the zero-prefill delay: it drops the first len input samples after reset/clear, then passes all later samples unchanged.
REQ-011 SHALL latch len into an internal len_r on the first cycle after reset/clear deasserts; changes to len later SHALL be ignored until the next clear.
REQ-012 SHALL have states DISCARD and PASS; the state after reset/clear SHALL be DISCARD, or PASS if len_r == 0.
REQ-013 In DISCARD, i_tready SHALL be 1 and o_tvalid SHALL be 0; each input beat (i_tvalid=1) SHALL increment drop_count.
REQ-014 DISCARD->PASS SHALL occur on the beat where drop_count+1 == len_r; that beat SHALL be dropped, and drop_count SHALL then hold.
REQ-015 drop_count SHALL be MAX_LEN_LOG2 bits, SHALL never wrap, and len_r = 2^MAX_LEN_LOG2-1 SHALL drop exactly that many samples.
REQ-016 In PASS, the output SHALL be a one-deep register stage: i_tready = ~o_tvalid | o_tready; an accepted beat SHALL appear on o_tdata/o_tlast with o_tvalid=1 on the next cycle (latency 1).
REQ-017 When accept and output handshake occur in the same cycle, the register SHALL reload with no bubble, sustaining 1 sample/cycle.
REQ-018 o_tdata/o_tlast SHALL hold stable while o_tvalid=1 and o_tready=0.
REQ-019 PASS SHALL persist until reset/clear; i_tlast SHALL NOT restart discarding.
REQ-020 discarding SHALL equal (state == DISCARD).

Reset
REQ-021 On reset or clear: o_tvalid=0, o_tdata=0, o_tlast=0, drop_count=0, carry flag=0, any held output beat discarded.
REQ-022 clear asserted mid-stream SHALL behave identically to reset, including re-latching len on the following cycle.
REQ-023 During reset/clear cycles, i_tready SHALL be 0.

Configuration
REQ-024 Macro SAMPLE_ADVANCE_LAST_CARRY_EN SHALL control tlast from discarded beats.
REQ-025 With SAMPLE_ADVANCE_LAST_CARRY_EN defined: if any dropped beat carries i_tlast=1, a carry flag SHALL set, and the first PASS output beat SHALL have o_tlast=1 (OR with its own i_tlast); the flag SHALL then clear.
REQ-026 Without it: tlast on dropped beats SHALL be discarded, and o_tlast SHALL equal the registered i_tlast.

Verification
REQ-027 len=4, input 1..10 continuous, o_tready=1 -> output 5..10, first o_tvalid 5 cycles after first input beat, discarding high for 4 beats.
REQ-028 len=0, input 7,8,9 -> output 7,8,9 with 1-cycle latency; discarding never high.
REQ-029 len=2, PASS, o_tready toggling 1,0,0,1 -> i_tready low while held, no sample lost/duplicated, o_tdata stable while stalled.
REQ-030 len=3, clear after output of sample 6 (input 1..10), then input 20..25 -> samples 20..22 dropped, 23..25 output.
REQ-031 len=2, i_tlast=1 on input beat 2 -> with macro: output beat 3 has o_tlast=1; without: o_tlast=0.
REQ-032 len changed from 4 to 1 during DISCARD -> still exactly 4 samples dropped.

Source files
------------

// File: rtl/sample_advance.sv
// Receive-side sample advance: drops the first len beats after reset/clear, then
// forwards the stream through a one-deep register stage. Option macro: SAMPLE_ADVANCE_LAST_CARRY_EN.
module sample_advance #(
  parameter int MAX_LEN_LOG2 = 10,
  parameter int WIDTH        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [MAX_LEN_LOG2-1:0] len,
  input  logic [WIDTH-1:0]        i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    discarding
);

  typedef enum logic [0:0] {
    DISCARD = 1'b0,
    PASS    = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_load;
  logic [MAX_LEN_LOG2-1:0] r_len;
  logic [MAX_LEN_LOG2-1:0] r_drop_count;
  logic [WIDTH-1:0]        r_tdata;
  logic                    r_tlast;
  logic                    r_tvalid;
`ifdef SAMPLE_ADVANCE_LAST_CARRY_EN
  logic                    r_carry;
`endif

  logic                    w_rst;
  logic [MAX_LEN_LOG2-1:0] w_len;
  state_t                  w_state;
  logic [MAX_LEN_LOG2:0]   w_drop_next;
  logic                    w_last_drop;
  logic                    w_accept;

  assign w_rst       = reset | clear;
  // On the latch cycle len is not yet in r_len, so the live value stands in for it.
  assign w_len       = r_load ? len : r_len;
  assign w_drop_next = {1'b0, r_drop_count} + {{MAX_LEN_LOG2{1'b0}}, 1'b1};
  assign w_last_drop = (w_drop_next == {1'b0, w_len});
  assign w_accept    = i_tvalid & i_tready;

  // Effective state, resolving the zero-length case on the latch cycle.
  always_comb begin
    w_state = r_state;
    if (r_load) begin
      if (len == {MAX_LEN_LOG2{1'b0}}) begin
        w_state = PASS;
      end else begin
        w_state = DISCARD;
      end
    end else begin
      w_state = r_state;
    end
  end

  // Input ready: always ready while dropping, register-slice rule while passing.
  always_comb begin
    i_tready = 1'b0;
    if (w_rst) begin
      i_tready = 1'b0;
    end else begin
      case (w_state)
        DISCARD: i_tready = 1'b1;
        PASS:    i_tready = ~r_tvalid | o_tready;
        default: i_tready = 1'b0;
      endcase
    end
  end

  // State, length latch, drop counter and output register stage.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_load       <= 1'b1;
      r_state      <= DISCARD;
      r_len        <= {MAX_LEN_LOG2{1'b0}};
      r_drop_count <= {MAX_LEN_LOG2{1'b0}};
      r_tdata      <= {WIDTH{1'b0}};
      r_tlast      <= 1'b0;
      r_tvalid     <= 1'b0;
`ifdef SAMPLE_ADVANCE_LAST_CARRY_EN
      r_carry      <= 1'b0;
`endif
    end else begin
      r_load  <= 1'b0;
      r_state <= w_state;
      if (r_load) begin
        r_len <= len;
      end
      case (w_state)
        DISCARD: begin
          r_tvalid <= 1'b0;
          if (i_tvalid) begin
            // The final drop leaves the counter in place so it can never wrap.
            if (w_last_drop) begin
              r_state <= PASS;
            end else begin
              r_drop_count <= w_drop_next[MAX_LEN_LOG2-1:0];
            end
`ifdef SAMPLE_ADVANCE_LAST_CARRY_EN
            if (i_tlast) begin
              r_carry <= 1'b1;
            end
`endif
          end
        end
        PASS: begin
          if (w_accept) begin
            r_tdata  <= i_tdata;
            r_tvalid <= 1'b1;
`ifdef SAMPLE_ADVANCE_LAST_CARRY_EN
            r_tlast  <= i_tlast | r_carry;
            r_carry  <= 1'b0;
`else
            r_tlast  <= i_tlast;
`endif
          end else if (o_tready) begin
            r_tvalid <= 1'b0;
          end
        end
        default: begin
          r_state  <= DISCARD;
          r_tvalid <= 1'b0;
        end
      endcase
    end
  end

  assign o_tdata    = r_tdata;
  assign o_tlast    = r_tlast;
  assign o_tvalid   = r_tvalid;
  assign discarding = (w_state == DISCARD);

endmodule

// File: tb/tb_sample_advance.sv
// Self-checking bench for sample_advance: vector table plus clear/len-change sequences,
// with a scoreboard queue filled on accepted input beats and drained on output handshakes.
module tb_sample_advance;
  localparam int N = 10;
  localparam int W = 16;
`ifdef SAMPLE_ADVANCE_LAST_CARRY_EN
  localparam int CARRY = 1;
`else
  localparam int CARRY = 0;
`endif

  logic         clk;
  logic         reset;
  logic         clear;
  logic [N-1:0] len;
  logic [W-1:0] i_tdata;
  logic         i_tlast;
  logic         i_tvalid;
  logic         i_tready;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;
  logic         discarding;

  sample_advance #(.MAX_LEN_LOG2(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .len(len),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .discarding(discarding)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    int len; int start; int nbeats; int mode; int last_at;
    int exp_outs; int exp_first; int exp_first_last; bit use_reset; int exp_lat;
  } vec_t;

  beat_t sb[$];
  beat_t e;
  vec_t  vecs[7];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int m_len = 0, m_cnt = 0, m_outs = 0, disc_beats = 0;
  int first_acc = -1, first_valid = -1, first_data = -1, first_last = -1;
  bit m_carry = 1'b0;
  bit stall_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic prev_last;
  int rmode = 0;
  int pidx = 0;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output-side backpressure pattern generator.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: o_tready = 1'b1;
        1: begin o_tready = pat[3 - pidx]; pidx = (pidx + 1) % 4; end
        2: o_tready = 1'($urandom_range(0, 1));
        3: o_tready = 1'b0;
        default: o_tready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset || clear) begin
      chk("i_tready_in_reset", int'(i_tready), 0);
      stall_prev = 1'b0;
    end else begin
      chk("discarding", int'(discarding), int'(m_cnt < m_len));
      if (m_cnt < m_len) begin
        chk("i_tready_discard", int'(i_tready), 1);
        chk("o_tvalid_discard", int'(o_tvalid), 0);
      end else begin
        chk("i_tready_pass", int'(i_tready), int'(!o_tvalid || o_tready));
      end
      if (stall_prev) begin
        chk("stall_valid", int'(o_tvalid), 1);
        chk("stall_data", int'(o_tdata), int'(prev_data));
        chk("stall_last", int'(o_tlast), int'(prev_last));
      end
      if (o_tvalid && first_valid < 0) first_valid = cyc;
      if (o_tvalid && o_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", int'(o_tdata), -1);
        end else begin
          e = sb.pop_front();
          chk("out_data", int'(o_tdata), int'(e.d));
          chk("out_last", int'(o_tlast), int'(e.l));
        end
        m_outs++;
        if (m_outs == 1) begin
          first_data = int'(o_tdata);
          first_last = int'(o_tlast);
        end
      end
      if (i_tvalid && i_tready) begin
        if (first_acc < 0) first_acc = cyc;
        if (discarding) disc_beats++;
        if (m_cnt >= m_len) begin
          sb.push_back({i_tdata, i_tlast | ((CARRY != 0) && m_carry)});
          m_carry = 1'b0;
        end else if (i_tlast) begin
          m_carry = 1'b1;
        end
        m_cnt++;
      end
      stall_prev = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end
  end

  task automatic restart(input bit use_rst, input int l);
    len = l[N-1:0];
    if (use_rst) reset = 1'b1;
    else clear = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    sb.delete();
    m_len = l; m_cnt = 0; m_carry = 1'b0; m_outs = 0; disc_beats = 0;
    first_acc = -1; first_valid = -1; first_data = -1; first_last = -1;
    reset = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send(input int d, input bit l);
    int t;
    logic acc;
    t = 0;
    i_tvalid = 1'b1;
    i_tdata  = d[W-1:0];
    i_tlast  = l;
    do begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", t, 0);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rmode = 0;
    while ((sb.size() != 0 || o_tvalid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", int'(t < 100), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; len = '0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    // len, start, nbeats, mode, last_at, outs, first, first_last, use_reset, latency
    vecs[0] = '{4,    1, 10,   0, 0, 6,  5,    0,     1'b1, 5};
    vecs[1] = '{0,    7, 3,    0, 0, 3,  7,    0,     1'b0, 1};
    vecs[2] = '{2,    1, 10,   1, 0, 8,  3,    0,     1'b0, -1};
    vecs[3] = '{2,    1, 5,    0, 2, 3,  3,    CARRY, 1'b0, 3};
    vecs[4] = '{1023, 0, 1026, 0, 0, 3,  1023, 0,     1'b0, 1024};
    vecs[5] = '{1,    1, 4,    2, 0, 3,  2,    0,     1'b0, -1};
    vecs[6] = '{3,    1, 20,   2, 5, 17, 4,    0,     1'b0, -1};

    repeat (3) begin @(posedge clk); #1; end
    chk("reset_o_tvalid", int'(o_tvalid), 0);
    chk("reset_o_tdata", int'(o_tdata), 0);
    chk("reset_o_tlast", int'(o_tlast), 0);

    foreach (vecs[k]) begin
      restart(vecs[k].use_reset, vecs[k].len);
      rmode = vecs[k].mode;
      for (int b = 0; b < vecs[k].nbeats; b++) send(vecs[k].start + b, (b + 1) == vecs[k].last_at);
      drain();
      chk($sformatf("v%0d_outs", k), m_outs, vecs[k].exp_outs);
      chk($sformatf("v%0d_first", k), first_data, vecs[k].exp_first);
      chk($sformatf("v%0d_first_last", k), first_last, vecs[k].exp_first_last);
      chk($sformatf("v%0d_dropped", k), disc_beats,
          (vecs[k].len < vecs[k].nbeats) ? vecs[k].len : vecs[k].nbeats);
      if (vecs[k].exp_lat >= 0)
        chk($sformatf("v%0d_latency", k), first_valid - first_acc, vecs[k].exp_lat);
    end

    // Clear mid-stream with a held output beat, then a fresh stream.
    restart(1'b0, 3);
    for (int b = 1; b <= 6; b++) send(b, 1'b0);
    drain();
    chk("clr_pre_outs", m_outs, 3);
    rmode = 3;
    @(posedge clk); #1;
    send(7, 1'b0);
    @(posedge clk); #1;
    chk("clr_held_valid", int'(o_tvalid), 1);
    chk("clr_held_data", int'(o_tdata), 7);
    restart(1'b0, 3);
    chk("clr_o_tvalid", int'(o_tvalid), 0);
    chk("clr_o_tdata", int'(o_tdata), 0);
    rmode = 0;
    @(posedge clk); #1;
    for (int b = 20; b <= 25; b++) send(b, 1'b0);
    drain();
    chk("clr_outs", m_outs, 3);
    chk("clr_first", first_data, 23);

    // len changes during DISCARD are ignored.
    restart(1'b0, 4);
    send(1, 1'b0);
    len = 10'd1;
    for (int b = 2; b <= 8; b++) send(b, 1'b0);
    drain();
    chk("lenchg_outs", m_outs, 4);
    chk("lenchg_first", first_data, 5);
    chk("lenchg_dropped", disc_beats, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
